sample_readout: RTL and testbench
=================================

SAMPLE_READOUT -- requirements
Module: sample_readout

Interface
REQ-001 Parameter ADDR_WIDTH, default 13: sample RAM address width; the widths below assume the default.
REQ-002 clock  in  1  sole clock; all logic on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin readout; sampled only in IDLE.
REQ-005 end_address  in  13  address of the newest recorded sample; latched on an accepted start.
REQ-006 read_count_x4  in  11  number of samples to send, divided by 4; latched on an accepted start.
REQ-007 read_en  out  1  RAM read strobe.
REQ-008 read_address  out  13  RAM read address.
REQ-009 read_data  in  8  RAM data, valid exactly 1 cycle after read_en.
REQ-010 tx_data  out  8  byte to the host transmitter.
REQ-011 tx_valid  out  1  tx_data holds a byte.
REQ-012 tx_ready  in  1  the transmitter accepts the byte in this cycle.
REQ-013 busy  out  1  high from an accepted start until done.
REQ-014 done  out  1  single-cycle pulse after the last byte transfers.

Function
REQ-015 The state machine SHALL have the states IDLE, FETCH, LOAD, SEND and FINISH.
REQ-016 IDLE + start: latch the inputs, set remaining = read_count_x4 << 2 (13-bit) and set busy; go to FETCH, or to FINISH if remaining == 0.
REQ-017 FETCH: read_en = 1 for exactly one cycle with read_address = the current address; go to LOAD.
REQ-018 LOAD: capture read_data into tx_data and set tx_valid; go to SEND. tx_valid therefore rises 2 cycles after read_en.
REQ-019 SEND: a byte transfers in any cycle where tx_valid && tx_ready; tx_data and tx_valid SHALL hold steady while tx_ready is low.
REQ-020 After the final byte of a sample transfers: address decrements by 1 (modulo 2^13) and remaining decrements by 1; go to FETCH if remaining is nonzero, otherwise to FINISH.
REQ-021 Samples SHALL be sent newest first: end_address, end_address-1, and so on. Address 0 wraps to 8191.
REQ-022 FINISH: done = 1 for one cycle, busy = 0 and tx_valid = 0 on the next edge; return to IDLE.
REQ-023 start while busy SHALL be ignored, with no effect on the latched values.
REQ-024 read_en SHALL never assert outside FETCH; at most one RAM read SHALL be outstanding.
REQ-025 tx_valid SHALL be low in IDLE, FETCH and FINISH.
REQ-026 A start in the same cycle as FINISH SHALL be ignored; a start is accepted only in IDLE.

Reset
REQ-027 With reset high at an edge, the next state SHALL be IDLE with read_en = 0, tx_valid = 0, busy = 0, done = 0, tx_data = 0 and read_address = 0.
REQ-028 Reset mid-transfer SHALL drop tx_valid at that edge, with no done pulse.
REQ-029 Reset SHALL take priority over start.

Configuration
REQ-030 The macro SAMPLE_READOUT_PAD32_EN selects the number of bytes sent per sample.
REQ-031 With SAMPLE_READOUT_PAD32_EN defined, each sample SHALL be sent as 4 bytes: the sample byte first, then 0x00, 0x00, 0x00. The 3 pad bytes come from SEND with no RAM read, and the sample ends after the 4th transfer.
REQ-032 Without SAMPLE_READOUT_PAD32_EN, each sample SHALL be sent as 1 byte.

Verification
REQ-033 Basic readout: no pad, RAM[n] = n[7:0], end_address = 10, read_count_x4 = 1, tx_ready held high -> tx_data sequence 0x0A, 0x09, 0x08, 0x07, then one done pulse; busy falls with done.
REQ-034 Wrap-around: end_address = 1, read_count_x4 = 1 -> read addresses 1, 0, 8191, 8190; bytes 0x01, 0x00, 0xFF, 0xFE.
REQ-035 Backpressure: tx_ready low for 5 cycles while tx_valid is high -> tx_data stable and no new read_en; resumes on tx_ready with no byte lost or duplicated.
REQ-036 Zero count: read_count_x4 = 0, start -> no read_en, no tx_valid; done 1 cycle after FINISH is entered, i.e. 2 cycles after start.
REQ-037 Pad mode (SAMPLE_READOUT_PAD32_EN defined), end_address = 5, read_count_x4 = 1 -> 16 bytes in the order 05 00 00 00 04 00 00 00 03 00 00 00 02 00 00 00; exactly 4 read_en pulses.
REQ-038 Reset after the 2nd byte of a 4-sample readout -> tx_valid and busy low on the next edge, no done pulse; a new start then begins again from the newly latched end_address.

Source files
------------

// File: rtl/sample_readout.sv
// rtl/sample_readout.sv - newest-first readout of a sample RAM into a byte transmitter
// Optional: define SAMPLE_READOUT_PAD32_EN to send each sample as 4 bytes (sample, 00, 00, 00).
module sample_readout #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_end_address,
    input  logic [ADDR_WIDTH-3:0] i_read_count_x4,
    output logic                  o_read_en,
    output logic [ADDR_WIDTH-1:0] o_read_address,
    input  logic [7:0]            i_read_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FINISH} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_read_en;
    logic                  w_xfer;
    logic                  w_last_byte;
    logic [ADDR_WIDTH-1:0] w_count;
`ifdef SAMPLE_READOUT_PAD32_EN
    logic [1:0]            r_byte_idx;
`endif

    assign w_count = {i_read_count_x4, 2'b00};
    assign w_xfer  = r_tx_valid & i_tx_ready;

`ifdef SAMPLE_READOUT_PAD32_EN
    assign w_last_byte = (r_byte_idx == 2'd3);
`else
    assign w_last_byte = 1'b1;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_read_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = (w_count == '0) ? FINISH : FETCH;
            end
            FETCH: begin
                w_read_en    = 1'b1;
                w_next_state = LOAD;
            end
            LOAD: w_next_state = SEND;
            SEND: begin
                // remaining still holds the pre-decrement value here
                if (w_xfer && w_last_byte)
                    w_next_state = (r_remaining == ADDR_WIDTH'(1)) ? FINISH : FETCH;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SAMPLE_READOUT_PAD32_EN
            r_byte_idx  <= 2'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_addr      <= i_end_address;
                        r_remaining <= w_count;
                        r_busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    r_tx_data  <= i_read_data;
                    r_tx_valid <= 1'b1;
`ifdef SAMPLE_READOUT_PAD32_EN
                    r_byte_idx <= 2'd0;
`endif
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_last_byte) begin
                            r_tx_valid  <= 1'b0;
                            r_addr      <= r_addr - ADDR_WIDTH'(1);
                            r_remaining <= r_remaining - ADDR_WIDTH'(1);
                        end
`ifdef SAMPLE_READOUT_PAD32_EN
                        else begin
                            r_tx_data  <= 8'h00;
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
`endif
                    end
                end
                FINISH: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_tx_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_read_en      = w_read_en;
    assign o_read_address = r_addr;
    assign o_tx_data      = r_tx_data;
    assign o_tx_valid     = r_tx_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_sample_readout.sv
// tb/tb_sample_readout.sv - bench for sample_readout: vector table, scoreboard queues, corner sequences
module tb_sample_readout;

`ifdef SAMPLE_READOUT_PAD32_EN
    localparam int BPS = 4;
`else
    localparam int BPS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] ea = '0;
    logic [10:0] cnt = '0;
    logic        read_en;
    logic [12:0] raddr;
    logic [7:0]  rdata = '0;
    logic [7:0]  txd;
    logic        txv;
    logic        txr = 1'b1;
    logic        busy;
    logic        done;

    sample_readout #(.ADDR_WIDTH(13)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_end_address  (ea),
        .i_read_count_x4(cnt),
        .o_read_en      (read_en),
        .o_read_address (raddr),
        .i_read_data    (rdata),
        .o_tx_data      (txd),
        .o_tx_valid     (txv),
        .i_tx_ready     (txr),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // RAM model: RAM[n] = n[7:0], one-cycle read latency
    always @(posedge clk) if (read_en) rdata <= raddr[7:0];

    typedef struct {
        logic [12:0] ea;
        logic [10:0] cnt;
        int          mode;       // 0 ready high, 1 random ready, 2 five-cycle stalls
        int          exp_reads;
    } vec_t;

    vec_t        vecs [6];
    int          tests = 0;
    int          fails = 0;
    int          reads = 0;
    int          xfers = 0;
    int          dones = 0;
    logic [12:0] exp_addr [$];
    logic [7:0]  exp_bytes [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        check(name, {31'd0, got}, {31'd0, exp});
    endtask

    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        re_d1 = 1'b0, re_d2 = 1'b0, rst_d1 = 1'b1, rst_d2 = 1'b1;

    always @(negedge clk) begin : monitor
        logic [12:0] pa;
        logic [7:0]  pb;
        logic        skip;
        skip = rst | rst_d1 | rst_d2;
        if (read_en) begin
            reads++;
            check_bit("read_expected", exp_addr.size() != 0, 1'b1);
            if (exp_addr.size() != 0) begin
                pa = exp_addr.pop_front();
                check("read_address", {19'd0, raddr}, {19'd0, pa});
            end
        end
        if (txv && txr) begin
            xfers++;
            check_bit("byte_expected", exp_bytes.size() != 0, 1'b1);
            if (exp_bytes.size() != 0) begin
                pb = exp_bytes.pop_front();
                check("tx_data", {24'd0, txd}, {24'd0, pb});
            end
        end
        if (!skip) begin
            if (re_d2 || (txv && !prev_valid))
                check_bit("valid_two_after_read", txv && !prev_valid, re_d2);
            if (prev_valid && !prev_ready) begin
                check_bit("hold_valid", txv, 1'b1);
                check("hold_data", {24'd0, txd}, {24'd0, prev_data});
            end
            if (read_en) begin
                check_bit("no_read_while_valid", txv, 1'b0);
                check_bit("single_outstanding", re_d1, 1'b0);
            end
        end
        if (done) begin
            dones++;
            check_bit("done_single_pulse", prev_done, 1'b0);
            check_bit("busy_low_with_done", busy, 1'b0);
            check_bit("busy_before_done", prev_busy, 1'b1);
            check("bytes_left_at_done", exp_bytes.size(), 0);
            check("reads_left_at_done", exp_addr.size(), 0);
        end
        prev_valid <= txv;
        prev_ready <= txr;
        prev_data  <= txd;
        prev_busy  <= busy;
        prev_done  <= done;
        re_d2      <= re_d1;
        re_d1      <= read_en;
        rst_d2     <= rst_d1;
        rst_d1     <= rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [12:0] e, input logic [10:0] c);
        logic [12:0] a;
        for (int s = 0; s < int'(c) * 4; s++) begin
            a = e - 13'(s);
            exp_addr.push_back(a);
            exp_bytes.push_back(a[7:0]);
            for (int k = 1; k < BPS; k++) exp_bytes.push_back(8'h00);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int budget;
        int low_left;
        bit armed;
        int r0;
        int d0;
        low_left = 0;
        armed    = 1'b1;
        r0       = reads;
        d0       = dones;
        push_expect(v.ea, v.cnt);
        ea    = v.ea;
        cnt   = v.cnt;
        start = 1'b1;
        txr   = 1'b1;
        tick();
        start  = 1'b0;
        budget = int'(v.cnt) * 4 * BPS * 16 + 40;
        for (int c = 0; c < budget && dones == d0; c++) begin
            if (c == 3) begin
                start = 1'b1;
                ea    = ~v.ea;
                cnt   = 11'd5;
            end else begin
                start = 1'b0;
            end
            case (v.mode)
                1: txr = 1'($urandom_range(0, 1));
                2: begin
                    if (txv && armed) begin
                        low_left = 5;
                        armed    = 1'b0;
                    end
                    if (!txv) armed = 1'b1;
                    if (low_left > 0) begin
                        txr = 1'b0;
                        low_left--;
                    end else begin
                        txr = 1'b1;
                    end
                end
                default: txr = 1'b1;
            endcase
            tick();
        end
        start = 1'b0;
        txr   = 1'b1;
        check("done_seen", dones - d0, 1);
        check("read_pulses", reads - r0, v.exp_reads);
        tick();
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0;
        int x0;
        vecs[0] = '{13'd10,   11'd1, 0, 4};
        vecs[1] = '{13'd1,    11'd1, 0, 4};
        vecs[2] = '{13'd8191, 11'd1, 2, 4};
        vecs[3] = '{13'd0,    11'd2, 1, 8};
        vecs[4] = '{13'd300,  11'd3, 1, 12};
        vecs[5] = '{13'd2,    11'd1, 2, 4};

        // reset held with start high: reset wins
        rst = 1'b1; start = 1'b1; ea = 13'd123; cnt = 11'd2;
        tick(); tick(); tick();
        check_bit("rst_read_en", read_en, 1'b0);
        check_bit("rst_tx_valid", txv, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check("rst_tx_data", {24'd0, txd}, 0);
        check("rst_read_address", {19'd0, raddr}, 0);
        rst = 1'b0; start = 1'b0;
        tick(); tick();

        // zero count; a start during FINISH must be ignored
        ea = 13'd5; cnt = 11'd0; start = 1'b1;
        tick();
        check_bit("zero_busy_in_finish", busy, 1'b1);
        check_bit("zero_no_done_yet", done, 1'b0);
        ea = 13'd77; cnt = 11'd1; start = 1'b1;
        tick();
        check_bit("zero_done", done, 1'b1);
        check_bit("zero_busy_low", busy, 1'b0);
        start = 1'b0;
        tick();
        check_bit("zero_done_once", done, 1'b0);
        check_bit("zero_finish_start_ignored", busy, 1'b0);
        tick(); tick(); tick();

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        // reset after the second transferred byte of a 4-sample readout
        d0 = dones;
        x0 = xfers;
        push_expect(13'd100, 11'd1);
        ea = 13'd100; cnt = 11'd1; start = 1'b1; txr = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && xfers < x0 + 2; c++) tick();
        check("two_bytes_before_reset", xfers - x0, 2);
        rst = 1'b1; txr = 1'b0;
        tick();
        check_bit("midrst_tx_valid", txv, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        exp_addr.delete();
        exp_bytes.delete();
        rst = 1'b0; txr = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("no_done_after_reset", dones - d0, 0);
        run_vector('{13'd50, 11'd1, 0, 4});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
